dcache_2way_ctrl: RTL and testbench

Parametrised successor to the single-way data cache behind the MEM stage of the 5-stage MIPS pipeline.
- 2-way set-associative, write-back, write-allocate cache with per-set LRU replacement and hit/miss performance counters.
- CPU side keeps the existing p1_* interface, so it drops into the CPU top unchanged.
- p1_stall_o freezes PC and Stage1–Stage4 while a miss is serviced.
- Memory side keeps the existing 256-bit line interface with the enable/ack handshake.

---
 rtl/dcache_2way_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dcache_2way_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_2way_ctrl.sv
// 2-way set-associative, write-back, write-allocate data cache controller for the
// MEM stage. Hits complete in zero cycles. Misses stall the pipeline while the
// victim is written back (if dirty) and the requested line is refilled.
module dcache_2way_ctrl #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned LINE_BITS = 256,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned SETS      = 16,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [ADDR_W-1:0]    p1_addr_i,
   input  logic [DATA_W-1:0]    p1_data_i,
   input  logic                 p1_MemRead_i,
   input  logic                 p1_MemWrite_i,
   output logic [DATA_W-1:0]    p1_data_o,
   output logic                 p1_stall_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i,
   output logic [LINE_BITS-1:0] mem_data_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [CNT_W-1:0]     hit_cnt_o,
   output logic [CNT_W-1:0]     miss_cnt_o
);

   localparam int unsigned OFFSET_W = $clog2(LINE_BITS / 8);
   localparam int unsigned INDEX_W  = $clog2(SETS);
   localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
   localparam int unsigned WORDS    = LINE_BITS / DATA_W;
   localparam int unsigned WORD_W   = $clog2(WORDS);
   localparam int unsigned LADDR_W  = TAG_W + INDEX_W;

   typedef logic [WORDS-1:0][DATA_W-1:0] line_t;
   typedef enum logic [1:0] {StIdle, StWriteback, StRefill, StInstall} state_e;

   state_e                   state_q;
   logic [1:0][SETS-1:0]     valid_q, dirty_q;
   logic [SETS-1:0]          lru_q;
   logic [TAG_W-1:0]         tag_q  [2][SETS];
   line_t                    line_q [2][SETS];
   logic                     victim_q;
   logic [LADDR_W-1:0]       req_line_q;
   logic                     mem_en_q, mem_wr_q;
   logic [ADDR_W-1:0]        mem_addr_q;
   logic [LINE_BITS-1:0]     mem_data_q;
   logic [CNT_W-1:0]         hit_cnt_q, miss_cnt_q;

   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] req_idx;
   logic [WORD_W-1:0]  req_word;
   logic [TAG_W-1:0]   ref_tag;
   logic [INDEX_W-1:0] ref_idx;
   logic               req, hit0, hit1, hit_any, hit_way, hit_now, miss_now;
   logic               victim, vict_dirty;
   logic               unused_addr;

   assign req_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
   assign req_idx  = p1_addr_i[OFFSET_W +: INDEX_W];
   assign req_word = p1_addr_i[OFFSET_W-1 -: WORD_W];
   assign ref_idx  = req_line_q[INDEX_W-1:0];
   assign ref_tag  = req_line_q[INDEX_W +: TAG_W];
   // Byte-within-word bits do not select anything.
   assign unused_addr = ^p1_addr_i[OFFSET_W-WORD_W-1:0];

   // Tag lookup, victim selection and CPU-side outputs.
   always_comb begin
      req        = p1_MemRead_i | p1_MemWrite_i;
      hit0       = valid_q[0][req_idx] & (tag_q[0][req_idx] == req_tag);
      hit1       = valid_q[1][req_idx] & (tag_q[1][req_idx] == req_tag);
      hit_any    = hit0 | hit1;
      hit_way    = hit0 ? 1'b0 : 1'b1;
      hit_now    = rst_i & (state_q == StIdle) & req & hit_any;
      miss_now   = rst_i & (state_q == StIdle) & req & ~hit_any;
      if (!valid_q[0][req_idx]) begin
         victim = 1'b0;
      end else if (!valid_q[1][req_idx]) begin
         victim = 1'b1;
      end else begin
         victim = lru_q[req_idx];
      end
      vict_dirty = valid_q[victim][req_idx] & dirty_q[victim][req_idx];
      p1_data_o  = hit_now ? line_q[hit_way][req_idx][req_word] : '0;
      // Stall on a miss in IDLE and throughout every non-IDLE state.
      p1_stall_o = rst_i & ((state_q != StIdle) | (req & ~hit_any));
   end

   assign mem_enable_o = mem_en_q;
   assign mem_write_o  = mem_wr_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;
   assign hit_cnt_o    = hit_cnt_q;
   assign miss_cnt_o   = miss_cnt_q;

   // Miss-handling FSM, status bits, registered memory outputs and counters.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= StIdle;
         valid_q    <= '0;
         dirty_q    <= '0;
         lru_q      <= '0;
         victim_q   <= 1'b0;
         req_line_q <= '0;
         mem_en_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (hit_now) begin
                  lru_q[req_idx] <= ~hit_way;
                  if (p1_MemWrite_i) dirty_q[hit_way][req_idx] <= 1'b1;
                  if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
               end else if (miss_now) begin
                  if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                  victim_q   <= victim;
                  req_line_q <= {req_tag, req_idx};
                  mem_en_q   <= 1'b1;
                  if (vict_dirty) begin
                     state_q    <= StWriteback;
                     mem_wr_q   <= 1'b1;
                     mem_addr_q <= {tag_q[victim][req_idx], req_idx, {OFFSET_W{1'b0}}};
                     mem_data_q <= line_q[victim][req_idx];
                  end else begin
                     state_q    <= StRefill;
                     mem_wr_q   <= 1'b0;
                     mem_addr_q <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                  end
               end
            end
            StWriteback: begin
               if (mem_ack_i) begin
                  state_q    <= StRefill;
                  mem_wr_q   <= 1'b0;
                  mem_addr_q <= {req_line_q, {OFFSET_W{1'b0}}};
               end
            end
            StRefill: begin
               if (mem_ack_i) begin
                  state_q                   <= StInstall;
                  valid_q[victim_q][ref_idx] <= 1'b1;
                  dirty_q[victim_q][ref_idx] <= 1'b0;
                  mem_en_q                  <= 1'b0;
               end
            end
            StInstall: state_q <= StIdle;
            default:   state_q <= StIdle;
         endcase
      end
   end

   // Tag and data arrays; left unreset since valid bits guard them.
   always_ff @(posedge clk_i) begin
      if (hit_now && p1_MemWrite_i) begin
         line_q[hit_way][req_idx][req_word] <= p1_data_i;
      end
      if (state_q == StRefill && mem_ack_i) begin
         line_q[victim_q][ref_idx] <= mem_data_i;
         tag_q[victim_q][ref_idx]  <= ref_tag;
      end
   end

endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Directed bench for dcache_2way_ctrl: refill, hits, writeback, LRU, reset, R+W.
module tb_dcache_2way_ctrl;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [31:0]  p1_addr_i;
   logic [31:0]  p1_data_i;
   logic         p1_MemRead_i;
   logic         p1_MemWrite_i;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;
   logic [255:0] mem_data_o;
   logic [31:0]  mem_addr_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [15:0]  hit_cnt_o;
   logic [15:0]  miss_cnt_o;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [255:0] line1, line2, line3, line4;

   dcache_2way_ctrl dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .p1_addr_i     (p1_addr_i),
      .p1_data_i     (p1_data_i),
      .p1_MemRead_i  (p1_MemRead_i),
      .p1_MemWrite_i (p1_MemWrite_i),
      .p1_data_o     (p1_data_o),
      .p1_stall_o    (p1_stall_o),
      .mem_data_i    (mem_data_i),
      .mem_ack_i     (mem_ack_i),
      .mem_data_o    (mem_data_o),
      .mem_addr_o    (mem_addr_o),
      .mem_enable_o  (mem_enable_o),
      .mem_write_o   (mem_write_o),
      .hit_cnt_o     (hit_cnt_o),
      .miss_cnt_o    (miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [255:0] mk_line(input logic [31:0] w0, input logic [31:0] step);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = w0 + step * i;
      return l;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d);
      p1_MemRead_i  = rd;
      p1_MemWrite_i = wr;
      p1_addr_i     = a;
      p1_data_i     = d;
   endtask

   task automatic ack_line(input logic [255:0] l, input int delay);
      repeat (delay) tick();
      mem_data_i = l;
      mem_ack_i  = 1'b1;
      tick();
      mem_ack_i  = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      set_req(1'b1, 1'b0, 32'h40, 32'h0);
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      total_cnt++;
      if (p1_stall_o !== 1'b0) $display("FAIL rst_stall: got %b need 0", p1_stall_o);
      else pass_cnt++;
      total_cnt++;
      if ({mem_enable_o, mem_write_o, mem_addr_o} !== 34'h0)
         $display("FAIL rst_mem: got en=%b wr=%b addr=%h need 0", mem_enable_o, mem_write_o,
                  mem_addr_o);
      else pass_cnt++;
      total_cnt++;
      if ({hit_cnt_o, miss_cnt_o, p1_data_o} !== 64'h0)
         $display("FAIL rst_cnt: got hit=%0d miss=%0d data=%h need 0", hit_cnt_o, miss_cnt_o,
                  p1_data_o);
      else pass_cnt++;
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      rst_i = 1'b1;
      tick();
   endtask

   // Scenario 1: cold read miss, refill, install, re-evaluated hit.
   task automatic test_read_miss_refill();
      set_req(1'b1, 1'b0, 32'h40, 32'h0);
      @(negedge clk_i);
      total_cnt++;
      if (p1_stall_o !== 1'b1) $display("FAIL miss_stall: got %b need 1", p1_stall_o);
      else pass_cnt++;
      tick();
      @(negedge clk_i);
      total_cnt++;
      if ({mem_enable_o, mem_write_o, mem_addr_o} !== {2'b10, 32'h40})
         $display("FAIL refill_req: got en=%b wr=%b addr=%h need en=1 wr=0 addr=40",
                  mem_enable_o, mem_write_o, mem_addr_o);
      else pass_cnt++;
      ack_line(line1, 9);
      @(negedge clk_i);
      total_cnt++;
      if ({mem_enable_o, p1_stall_o} !== 2'b01)
         $display("FAIL install: got en=%b stall=%b need en=0 stall=1", mem_enable_o,
                  p1_stall_o);
      else pass_cnt++;
      tick();
      @(negedge clk_i);
      total_cnt++;
      if ({p1_stall_o, p1_data_o} !== {1'b0, 32'h1111_1111})
         $display("FAIL reeval_hit: got stall=%b data=%h need 0/11111111", p1_stall_o,
                  p1_data_o);
      else pass_cnt++;
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      total_cnt++;
      if ({hit_cnt_o, miss_cnt_o} !== {16'd1, 16'd1})
         $display("FAIL s1_cnt: got hit=%0d miss=%0d need 1/1", hit_cnt_o, miss_cnt_o);
      else pass_cnt++;
   endtask

   // Scenario 2: zero-latency read hit, then idle cycles.
   task automatic test_read_hit_idle();
      tick();
      set_req(1'b1, 1'b0, 32'h44, 32'h0);
      @(negedge clk_i);
      total_cnt++;
      if ({p1_stall_o, mem_enable_o, p1_data_o} !== {2'b00, 32'h2222_2222})
         $display("FAIL hit44: got stall=%b en=%b data=%h need 0/0/22222222", p1_stall_o,
                  mem_enable_o, p1_data_o);
      else pass_cnt++;
      tick();
      set_req(1'b0, 1'b0, 32'h44, 32'h0);
      @(negedge clk_i);
      total_cnt++;
      if (p1_data_o !== 32'h0) $display("FAIL noreq_data: got %h need 0", p1_data_o);
      else pass_cnt++;
      repeat (5) tick();
      @(negedge clk_i);
      total_cnt++;
      if ({hit_cnt_o, miss_cnt_o, p1_stall_o} !== {16'd2, 16'd1, 1'b0})
         $display("FAIL idle_cnt: got hit=%0d miss=%0d stall=%b need 2/1/0", hit_cnt_o,
                  miss_cnt_o, p1_stall_o);
      else pass_cnt++;
   endtask

   // Scenario 3: dirty way0, fill way1, then evict way0 through writeback.
   task automatic test_writeback();
      tick();
      set_req(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
      @(negedge clk_i);
      total_cnt++;
      if (p1_stall_o !== 1'b0) $display("FAIL wr_hit: got stall=%b need 0", p1_stall_o);
      else pass_cnt++;
      tick();
      set_req(1'b1, 1'b0, 32'h240, 32'h0);
      tick();
      @(negedge clk_i);
      total_cnt++;
      if ({mem_enable_o, mem_write_o, mem_addr_o} !== {2'b10, 32'h240})
         $display("FAIL fill240: got en=%b wr=%b addr=%h need en=1 wr=0 addr=240",
                  mem_enable_o, mem_write_o, mem_addr_o);
      else pass_cnt++;
      ack_line(line2, 2);
      tick();
      @(negedge clk_i);
      total_cnt++;
      if (p1_data_o !== 32'h2400_0000) $display("FAIL rd240: got %h need 24000000", p1_data_o);
      else pass_cnt++;
      tick();
      set_req(1'b1, 1'b0, 32'h440, 32'h0);
      @(negedge clk_i);
      total_cnt++;
      if (p1_stall_o !== 1'b1) $display("FAIL miss440: got stall=%b need 1", p1_stall_o);
      else pass_cnt++;
      tick();
      @(negedge clk_i);
      total_cnt++;
      if ({mem_enable_o, mem_write_o, mem_addr_o, mem_data_o[31:0]} !==
          {2'b11, 32'h40, 32'hDEAD_BEEF})
         $display("FAIL wb_req: got en=%b wr=%b addr=%h d0=%h need 1/1/40/deadbeef",
                  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o[31:0]);
      else pass_cnt++;
      ack_line('0, 3);
      @(negedge clk_i);
      total_cnt++;
      if ({mem_enable_o, mem_write_o, mem_addr_o} !== {2'b10, 32'h440})
         $display("FAIL wb_refill: got en=%b wr=%b addr=%h need en=1 wr=0 addr=440",
                  mem_enable_o, mem_write_o, mem_addr_o);
      else pass_cnt++;
      ack_line(line3, 2);
      tick();
      @(negedge clk_i);
      total_cnt++;
      if ({p1_stall_o, p1_data_o} !== {1'b0, 32'h4400_0000})
         $display("FAIL rd440: got stall=%b data=%h need 0/44000000", p1_stall_o, p1_data_o);
      else pass_cnt++;
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      total_cnt++;
      if ({hit_cnt_o, miss_cnt_o} !== {16'd5, 16'd3})
         $display("FAIL s3_cnt: got hit=%0d miss=%0d need 5/3", hit_cnt_o, miss_cnt_o);
      else pass_cnt++;
   endtask

   // Scenario 4: hit on way1 moves LRU to way0; next miss evicts clean way0.
   task automatic test_lru_hit();
      tick();
      set_req(1'b1, 1'b0, 32'h240, 32'h0);
      @(negedge clk_i);
      total_cnt++;
      if ({p1_stall_o, p1_data_o} !== {1'b0, 32'h2400_0000})
         $display("FAIL lru_hit240: got stall=%b data=%h need 0/24000000", p1_stall_o,
                  p1_data_o);
      else pass_cnt++;
      tick();
      set_req(1'b1, 1'b0, 32'h640, 32'h0);
      tick();
      @(negedge clk_i);
      total_cnt++;
      if ({mem_enable_o, mem_write_o, mem_addr_o} !== {2'b10, 32'h640})
         $display("FAIL evict440: got en=%b wr=%b addr=%h need en=1 wr=0 addr=640",
                  mem_enable_o, mem_write_o, mem_addr_o);
      else pass_cnt++;
      ack_line(line4, 1);
      tick();
      tick();
      set_req(1'b1, 1'b0, 32'h240, 32'h0);
      @(negedge clk_i);
      total_cnt++;
      if ({p1_stall_o, p1_data_o} !== {1'b0, 32'h2400_0000})
         $display("FAIL keep240: got stall=%b data=%h need 0/24000000", p1_stall_o, p1_data_o);
      else pass_cnt++;
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      total_cnt++;
      if ({hit_cnt_o, miss_cnt_o} !== {16'd8, 16'd4})
         $display("FAIL s4_cnt: got hit=%0d miss=%0d need 8/4", hit_cnt_o, miss_cnt_o);
      else pass_cnt++;
   endtask

   // Scenario 5: reset while a refill is outstanding.
   task automatic test_reset_mid_refill();
      tick();
      set_req(1'b1, 1'b0, 32'h40, 32'h0);
      tick();
      tick();
      @(negedge clk_i);
      total_cnt++;
      if (mem_enable_o !== 1'b1) $display("FAIL mid_en: got %b need 1", mem_enable_o);
      else pass_cnt++;
      #2;
      rst_i = 1'b0;
      #1;
      total_cnt++;
      if ({mem_enable_o, p1_stall_o} !== 2'b00)
         $display("FAIL mid_rst: got en=%b stall=%b need 0/0", mem_enable_o, p1_stall_o);
      else pass_cnt++;
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      rst_i = 1'b1;
      tick();
      set_req(1'b1, 1'b0, 32'h40, 32'h0);
      @(negedge clk_i);
      total_cnt++;
      if (p1_stall_o !== 1'b1) $display("FAIL post_rst_miss: got %b need 1", p1_stall_o);
      else pass_cnt++;
      tick();
      @(negedge clk_i);
      total_cnt++;
      if ({mem_enable_o, mem_write_o, mem_addr_o, miss_cnt_o, hit_cnt_o} !==
          {2'b10, 32'h40, 16'd1, 16'd0})
         $display("FAIL post_rst_req: got en=%b wr=%b addr=%h miss=%0d hit=%0d need 1/0/40/1/0",
                  mem_enable_o, mem_write_o, mem_addr_o, miss_cnt_o, hit_cnt_o);
      else pass_cnt++;
      ack_line(line1, 1);
      tick();
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Scenario 6: read and write together act as a write.
   task automatic test_both_rw();
      tick();
      set_req(1'b1, 1'b1, 32'h44, 32'h5);
      @(negedge clk_i);
      total_cnt++;
      if (p1_stall_o !== 1'b0) $display("FAIL rw_hit: got stall=%b need 0", p1_stall_o);
      else pass_cnt++;
      tick();
      set_req(1'b1, 1'b0, 32'h44, 32'h0);
      @(negedge clk_i);
      total_cnt++;
      if (p1_data_o !== 32'h5) $display("FAIL rw_read: got %h need 00000005", p1_data_o);
      else pass_cnt++;
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      total_cnt++;
      if ({hit_cnt_o, miss_cnt_o} !== {16'd3, 16'd1})
         $display("FAIL s6_cnt: got hit=%0d miss=%0d need 3/1", hit_cnt_o, miss_cnt_o);
      else pass_cnt++;
   endtask

   initial begin
      line1 = mk_line(32'h1111_1111, 32'h1111_1111);
      line2 = mk_line(32'h2400_0000, 32'h1);
      line3 = mk_line(32'h4400_0000, 32'h1);
      line4 = mk_line(32'h6400_0000, 32'h1);
      test_reset();
      test_read_miss_refill();
      test_read_hit_idle();
      test_writeback();
      test_lru_hit();
      test_reset_mid_refill();
      test_both_rw();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
